// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives imem, pairs each 1-cycle imem response
// with its PC and presents {pc, instr} to decode over valid/ready.
// A single hold entry absorbs decode backpressure; redirects flush the
// in-flight fetch and restart at the aligned target.
module instr_fetch #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'('h01000000)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target
);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic               req_valid, req_valid_next;
  logic [ADDR_W-1:0]  req_pc, req_pc_next;
  logic [ADDR_W-1:0]  hold_pc, hold_pc_next;
  logic [INSTR_W-1:0] hold_instr, hold_instr_next;
  logic               issue;

  // Decode-side view and fetch issue: a redirect or reset suppresses both.
  // In STALL the hold entry is presented; in RUN the live imem response is.
  always_comb begin
    issue    = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_instr = '0;
    if (!rst && !redirect_valid) begin
      if (state == RUN) begin
        issue    = !req_valid || if_ready;
        if_valid = req_valid;
        if (req_valid) begin
          if_pc    = req_pc;
          if_instr = imem_instr;
        end
      end else begin
        issue    = if_ready;
        if_valid = 1'b1;
        if_pc    = hold_pc;
        if_instr = hold_instr;
      end
    end
    imem_en   = issue;
    imem_addr = pc;
  end

  // Next-state: redirect first, then capture into the hold entry on
  // backpressure, otherwise issue the next sequential fetch.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    req_valid_next  = req_valid;
    req_pc_next     = req_pc;
    hold_pc_next    = hold_pc;
    hold_instr_next = hold_instr;
    if (redirect_valid) begin
      state_next      = RUN;
      req_valid_next  = 1'b0;
      pc_next         = {redirect_target[ADDR_W-1:2], 2'b00};
      hold_pc_next    = '0;
      hold_instr_next = '0;
    end else if (state == RUN && req_valid && !if_ready) begin
      state_next      = STALL;
      req_valid_next  = 1'b0;
      hold_pc_next    = req_pc;
      hold_instr_next = imem_instr;
    end else if (issue) begin
      state_next     = RUN;
      req_valid_next = 1'b1;
      req_pc_next    = pc;
      pc_next        = pc + ADDR_W'(4);
    end else begin
      req_valid_next = 1'b0;
    end
  end

  // State registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_VECTOR;
      req_valid  <= 1'b0;
      req_pc     <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      req_valid  <= req_valid_next;
      req_pc     <= req_pc_next;
      hold_pc    <= hold_pc_next;
      hold_instr <= hold_instr_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized ready/redirect/reset traffic, checked against a stream model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_VECTOR = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_instr = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;

  int checks = 0;
  int errors = 0;

  // Stream model: the PC decode should see next, and what the previous
  // cycle implies for the current one.
  logic [31:0] exp_pc = RESET_VECTOR;
  logic        prev_fresh = 1'b1;
  logic        prev_stall = 1'b0;

  instr_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_VECTOR(RESET_VECTOR)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_en         (imem_en),
    .imem_instr      (imem_instr),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  always #5 clk = ~clk;

  // Program image: the four preloaded words, a scrambled address elsewhere.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    case (a)
      32'h01000000: return 32'h00100093;
      32'h01000004: return 32'h00200113;
      32'h01000008: return 32'h002080b3;
      32'h0100000C: return 32'hffdff06f;
      default:      return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endcase
  endfunction

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_instr <= instr_at(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the settled
  // outputs, then advance the model by what the rising edge will do.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] tgt);
    logic exp_valid;
    @(negedge clk);
    if_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    if (rv)              exp_valid = 1'b0;
    else if (prev_fresh) exp_valid = 1'b0;
    else                 exp_valid = 1'b1;
    checkOutput("valid", if_valid, exp_valid);
    if (rv) checkOutput("redirect_en", imem_en, 0);
    if (exp_valid) begin
      checkOutput("pc", if_pc, exp_pc);
      checkOutput("instr", if_instr, instr_at(exp_pc));
      if (!rdy) checkOutput("stall_en", imem_en, 0);
    end else begin
      checkOutput("idle_pc", if_pc, 0);
      checkOutput("idle_instr", if_instr, 0);
    end
    if (rv)                   exp_pc = tgt & 32'hFFFFFFFC;
    else if (exp_valid && rdy) exp_pc = exp_pc + 32'd4;
    prev_fresh = rv;
    prev_stall = exp_valid && !rdy;
  endtask

  // Assert reset between edges, check outputs collapse at once, then release.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    redirect_valid = 1'b0;
    #1;
    checkOutput("rst_valid", if_valid, 0);
    checkOutput("rst_en", imem_en, 0);
    checkOutput("rst_addr", imem_addr, RESET_VECTOR);
    checkOutput("rst_pc", if_pc, 0);
    checkOutput("rst_instr", if_instr, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_pc     = RESET_VECTOR;
    prev_fresh = 1'b1;
    prev_stall = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;

    // Power-on reset, then a free-flowing stream from the reset vector.
    do_reset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0);

    // Backpressure: 01000004 presented with ready low for 3 cycles.
    do_reset();
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);

    // Redirect with an unaligned target while 0C is in flight.
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'h01000002);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

    // Redirect during a stall, with ready high on the redirect cycle.
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'h00002000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);

    // Reset mid-stream, then restart from the reset vector.
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);

    // Address wrap from the top of the space.
    applyStimulus(1'b1, 1'b1, 32'hFFFFFFFC);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 | (tgt & 32'hF);
      applyStimulus(rdy, rv, tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
